// File: rtl/osrx_ser_gen.sv
// osrx_ser_gen: single-clock N:1 multi-lane output serializer.
// Accepts one LANES*RATIO word per RATIO-clock frame over DVALID/DREADY.
// Ports: ECLK bit clock; RST sync active-high reset; D parallel word
//   (lane L bit k = D[L*RATIO+k]); DVALID word valid; DREADY accept
//   strobe; Q serial bit per lane; UPDATE last bit-time of each frame;
//   UNDERRUN one-cycle pulse when a frame boundary saw no DVALID.
// Optional macro OSRX_TRAIN_EN adds input TRAIN: loads TRAIN_PAT on every
//   lane at a frame boundary instead of D, without consuming D.
module osrx_ser_gen #(
  parameter int    RATIO     = 4,
  parameter int    LANES     = 1,
  parameter string REGSET    = "RESET",
  parameter bit    LSB_FIRST = 1'b1
`ifdef OSRX_TRAIN_EN
  ,
  parameter logic [RATIO-1:0] TRAIN_PAT = {{(RATIO-1){1'b0}}, 1'b1}
`endif
) (
  input  logic                   ECLK,
  input  logic                   RST,
`ifdef OSRX_TRAIN_EN
  input  logic                   TRAIN,
`endif
  input  logic [LANES*RATIO-1:0] D,
  input  logic                   DVALID,
  output logic                   DREADY,
  output logic [LANES-1:0]       Q,
  output logic                   UPDATE,
  output logic                   UNDERRUN
);

  localparam bit REG_OK = (REGSET == "RESET") || (REGSET == "SET");

  generate
    if (RATIO < 2 || RATIO > 16 || LANES < 1 || LANES > 32 || !REG_OK)
    begin : g_bad_cfg
      $fatal(1, "osrx_ser_gen: illegal RATIO/LANES/REGSET");
    end
  endgenerate

  localparam int            CW   = $clog2(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
  localparam logic          IDLE = (REGSET == "SET");
  localparam logic [LANES*RATIO-1:0] IDLE_W = {(LANES*RATIO){IDLE}};

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LANES*RATIO-1:0] hold_q, hold_d;
  logic [LANES-1:0]       q_q, q_d;
  logic                   upd_q, upd_d;
  logic                   und_q, und_d;
  logic                   load;
  logic [CW-1:0]          sel;
  logic [RATIO-1:0]       lane_w;

  // The load edge is the one closing a frame; UPDATE marks it a cycle early.
  assign load = (cnt_q == LAST);

  always_comb begin
    cnt_d  = load ? '0 : cnt_q + 1'b1;
    upd_d  = (cnt_d == LAST);
    hold_d = hold_q;
    und_d  = 1'b0;
    if (load) begin
`ifdef OSRX_TRAIN_EN
      if (TRAIN) hold_d = {LANES{TRAIN_PAT}};
      else
`endif
      if (DVALID) begin
        hold_d = D;
      end else begin
        hold_d = IDLE_W;
        und_d  = 1'b1;
      end
    end
    // Drive from hold_d so the first bit of a new word leaves on the load edge.
    sel    = LSB_FIRST ? cnt_d : LAST - cnt_d;
    q_d    = '0;
    lane_w = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_w = hold_d[l*RATIO +: RATIO];
      q_d[l] = lane_w[sel];
    end
  end

  always_ff @(posedge ECLK) begin
    if (RST) begin
      cnt_q  <= '0;
      hold_q <= IDLE_W;
      q_q    <= {LANES{IDLE}};
      upd_q  <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      q_q    <= q_d;
      upd_q  <= upd_d;
      und_q  <= und_d;
    end
  end

  assign Q        = q_q;
  assign UPDATE   = upd_q;
  assign UNDERRUN = und_q;
`ifdef OSRX_TRAIN_EN
  assign DREADY   = upd_q & ~TRAIN;
`else
  assign DREADY   = upd_q;
`endif

endmodule

// File: tb/tb_osrx_ser_gen.sv
// tb_osrx_ser_gen: three serializer configs against a frame-level model.
// Directed literal sequences first, then randomized traffic and resets.
module tb_osrx_ser_gen;
`ifdef OSRX_TRAIN_EN
  localparam bit TRN_EN = 1'b1;
`else
  localparam bit TRN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, dv, dv2, trn;
  logic [3:0]  d;
  logic [15:0] d2;
  logic        q0, q1;
  logic [1:0]  q2;
  logic        up0, up1, up2, un0, un1, un2, dr0, dr1, dr2;

  osrx_ser_gen #(.RATIO(4), .LANES(1), .REGSET("RESET"), .LSB_FIRST(1'b1))
  u0 (.ECLK(clk), .RST(rst),
`ifdef OSRX_TRAIN_EN
      .TRAIN(trn),
`endif
      .D(d), .DVALID(dv), .DREADY(dr0), .Q(q0), .UPDATE(up0),
      .UNDERRUN(un0));

  osrx_ser_gen #(.RATIO(4), .LANES(1), .REGSET("RESET"), .LSB_FIRST(1'b0))
  u1 (.ECLK(clk), .RST(rst),
`ifdef OSRX_TRAIN_EN
      .TRAIN(trn),
`endif
      .D(d), .DVALID(dv), .DREADY(dr1), .Q(q1), .UPDATE(up1),
      .UNDERRUN(un1));

  osrx_ser_gen #(.RATIO(8), .LANES(2), .REGSET("SET"), .LSB_FIRST(1'b1))
  u2 (.ECLK(clk), .RST(rst),
`ifdef OSRX_TRAIN_EN
      .TRAIN(trn),
`endif
      .D(d2), .DVALID(dv2), .DREADY(dr2), .Q(q2), .UPDATE(up2),
      .UNDERRUN(un2));

  logic [1:0] aq [3];
  logic       au [3], an [3], ar [3];
  assign aq[0] = {1'b0, q0};
  assign aq[1] = {1'b0, q1};
  assign aq[2] = q2;
  assign au[0] = up0; assign au[1] = up1; assign au[2] = up2;
  assign an[0] = un0; assign an[1] = un1; assign an[2] = un2;
  assign ar[0] = dr0; assign ar[1] = dr1; assign ar[2] = dr2;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: n = bit-time index in the current frame,
  // w = word being shifted out, acc = word consumed at the last edge.
  int         R    [3] = '{4, 4, 8};
  int         LN   [3] = '{1, 1, 2};
  bit         IDL  [3] = '{1'b0, 1'b0, 1'b1};
  bit         LSBF [3] = '{1'b1, 1'b0, 1'b1};
  int         n    [3];
  logic [15:0] w   [3];
  bit         eund [3];
  bit         acc  [3];
  bit         mon = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit          v;
      logic [15:0] dd;
      logic [15:0] pw;
      v  = (i < 2) ? dv : dv2;
      dd = (i < 2) ? {12'h000, d} : d2;
      pw = '0;
      for (int l = 0; l < LN[i]; l++) pw[l*R[i]] = 1'b1;
      if (rst) begin
        n[i]    = 0;
        w[i]    = IDL[i] ? 16'hFFFF : 16'h0000;
        eund[i] = 1'b0;
        acc[i]  = 1'b0;
        mon     = 1'b1;
      end else begin
        acc[i]  = 1'b0;
        eund[i] = 1'b0;
        if (n[i] == R[i] - 1) begin
          if (trn && TRN_EN) begin
            w[i] = pw;
          end else if (v) begin
            w[i]   = dd;
            acc[i] = 1'b1;
          end else begin
            w[i]    = IDL[i] ? 16'hFFFF : 16'h0000;
            eund[i] = 1'b1;
          end
        end
        n[i] = (n[i] + 1) % R[i];
      end
    end
  end

  function automatic logic [1:0] expq(input int i);
    logic [1:0] r;
    int         b;
    r = '0;
    b = LSBF[i] ? n[i] : R[i] - 1 - n[i];
    for (int l = 0; l < LN[i]; l++) r[l] = w[i][l*R[i] + b];
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon) begin
      for (int i = 0; i < 3; i++) begin
        bit eu;
        eu = (n[i] == R[i] - 1);
        chk($sformatf("Q%0d", i), 16'(aq[i]), 16'(expq(i)));
        chk($sformatf("UPDATE%0d", i), 16'(au[i]), 16'(eu));
        chk($sformatf("UNDERRUN%0d", i), 16'(an[i]), 16'(eund[i]));
        chk($sformatf("DREADY%0d", i), 16'(ar[i]),
            16'(eu && !(trn && TRN_EN)));
      end
    end
  end

  logic       hq0 [0:52];
  logic       hq1 [0:52];
  logic [1:0] hq2 [0:52];
  logic       hup [0:52];
  logic       hun [0:52];
  logic       hdr [0:52];

  initial begin
    logic [15:0] z;
    rst = 1'b1; dv = 1'b0; dv2 = 1'b0; d = '0; d2 = '0; trn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q0", 16'(q0), 16'h0);
    chk("rst_q2_set", 16'(q2), 16'h3);
    chk("rst_upd", 16'(up0), 16'h0);
    chk("rst_und", 16'(un0), 16'h0);
    chk("rst_drdy", 16'(dr0), 16'h0);
    #2;
    rst = 1'b0; d = 4'b1011; dv = 1'b1; d2 = 16'hA53C; dv2 = 1'b1;

    for (int i = 1; i <= 52; i++) begin
      @(negedge clk);
      hq0[i] = q0; hq1[i] = q1; hq2[i] = q2;
      hup[i] = up0; hun[i] = un0;
      #2;
      case (i)
        16: dv = 1'b0;
        20: begin dv = 1'b1; d = 4'b0110; end
        24: d = 4'b1111;
        28: d = 4'b1100;
        30: rst = 1'b1;
        31: rst = 1'b0;
        39: d = 4'hF;
        42: trn = TRN_EN;
        43: trn = 1'b0;
        default: ;
      endcase
      #1 hdr[i] = dr0;
    end

    chk("upd_first_rise", 16'({hup[1], hup[2], hup[3]}), 16'b001);
    chk("lsb_seq", 16'({hq0[4], hq0[5], hq0[6], hq0[7]}), 16'b1101);
    chk("lsb_seq_nogap", 16'({hq0[8], hq0[9], hq0[10], hq0[11]}),
        16'b1101);
    chk("msb_seq", 16'({hq1[4], hq1[5], hq1[6], hq1[7]}), 16'b1011);
    z = '0;
    for (int i = 1; i <= 7; i++) z[i] = &hq2[i];
    chk("set_idle_before_load", z, 16'h00FE);
    chk("r8_lane0", 16'({hq2[8][0], hq2[9][0], hq2[10][0], hq2[11][0],
        hq2[12][0], hq2[13][0], hq2[14][0], hq2[15][0]}), 16'b00111100);
    chk("r8_lane1", 16'({hq2[8][1], hq2[9][1], hq2[10][1], hq2[11][1],
        hq2[12][1], hq2[13][1], hq2[14][1], hq2[15][1]}), 16'b10100101);
    z = '0;
    for (int i = 1; i <= 16; i++) z[i-1] = hun[i];
    chk("no_underrun_streaming", z, 16'h0000);
    chk("underrun_pulse", 16'({hun[19], hun[20], hun[21]}), 16'b010);
    chk("underrun_idle_frame", 16'({hq0[20], hq0[21], hq0[22], hq0[23]}),
        16'b0000);
    chk("resume_after_under", 16'({hq0[24], hq0[25], hq0[26], hq0[27]}),
        16'b0110);
    chk("pre_abort_bits", 16'({hq0[29], hq0[30]}), 16'b11);
    chk("abort_no_resume", 16'({hq0[31], hq0[32], hq0[33], hq0[34]}),
        16'b0000);
    chk("upd_after_rst", 16'({hup[31], hup[32], hup[33], hup[34]}),
        16'b0001);
    chk("rst_mid_q2_idle", 16'(hq2[31]), 16'h3);
    chk("first_load_after_rst", 16'({hq0[35], hq0[36], hq0[37], hq0[38]}),
        16'b0011);
`ifdef OSRX_TRAIN_EN
    chk("train_q0", 16'({hq0[43], hq0[44], hq0[45], hq0[46]}), 16'b1000);
    chk("train_q1", 16'({hq1[43], hq1[44], hq1[45], hq1[46]}), 16'b0001);
    chk("train_dready", 16'(hdr[42]), 16'h0);
    chk("train_no_underrun", 16'(hun[43]), 16'h0);
    chk("pending_after_train", 16'({hq0[47], hq0[48], hq0[49], hq0[50]}),
        16'b1111);
`else
    chk("dready_at_load", 16'(hdr[42]), 16'h1);
    chk("load_F", 16'({hq0[43], hq0[44], hq0[45], hq0[46]}), 16'b1111);
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #2;
      rst = ($urandom_range(0, 99) == 0);
      if (!dv || acc[0]) begin
        dv = ($urandom_range(0, 7) != 0);
        d  = 4'($urandom);
      end
      if (!dv2 || acc[2]) begin
        dv2 = ($urandom_range(0, 7) != 0);
        d2  = 16'($urandom);
      end
      trn = TRN_EN && ($urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
